// File: rtl/data_mem_pkg.sv
// Shared encodings and helpers for the MEM-stage data memory controller.
package data_mem_pkg;

    localparam logic [1:0] ACC_WORD = 2'b00;
    localparam logic [1:0] ACC_HALF = 2'b01;
    localparam logic [1:0] ACC_BYTE = 2'b10;
    localparam logic [1:0] ACC_RSVD = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    // Source of the data presented on rdata during RESP.
    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_RAM  = 2'b01,
        SRC_IO   = 2'b10
    } rsp_src_e;

    // Byte-lane write mask for an access of the given type at byte offset a.
    function automatic logic [3:0] lane_mask(input logic [1:0] acc_type, input logic [1:0] a);
        logic [3:0] m;
        m = '0;
        case (acc_type)
            ACC_WORD: m = 4'b1111;
            ACC_HALF: m = a[1] ? 4'b1100 : 4'b0011;
            ACC_BYTE: m = 4'b0001 << a;
            default:  m = '0;
        endcase
        return m;
    endfunction

    // Zero- or sign-extend an LSB-aligned half/byte; words pass through.
    function automatic logic [31:0] sext(input logic [31:0] data, input logic [1:0] acc_type,
                                         input logic sign_m);
        logic [31:0] r;
        case (acc_type)
            ACC_HALF: r = {(sign_m ? {16{data[15]}} : 16'h0000), data[15:0]};
            ACC_BYTE: r = {(sign_m ? {24{data[7]}} : 24'h00_0000), data[7:0]};
            default:  r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_lanes.sv
// Four independent 8-bit RAM banks with per-lane write enable and a
// registered, write-first read port sharing one word address.
module dmem_byte_lanes #(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           re,
    input  logic [3:0]                     we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem [DEPTH_WORDS];
        logic [7:0] rd_q;

        // Bank write and write-first synchronous read for this lane.
        always_ff @(posedge clk) begin
            if (we[l]) begin
                mem[addr] <= wdata[8*l +: 8];
            end
            if (re) begin
                rd_q <= we[l] ? wdata[8*l +: 8] : mem[addr];
            end
        end

        assign rdata[8*l +: 8] = rd_q;
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory: byte-addressed RAM plus memory-mapped IO ports,
// valid/ready request, one-cycle registered response with fault reporting.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned NUM_OUT     = 2,
    parameter int unsigned NUM_IN      = 2,
    parameter logic [31:0] IO_BASE     = 32'hFFFF_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   rw,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    input  logic [1:0]             acc_type,
    input  logic                   sign_m,
    output logic                   rsp_valid,
    output logic [31:0]            rdata,
    output logic                   err,
    output logic [7:0]             err_count,
    output logic [NUM_OUT*8-1:0]   out_port,
    input  logic [NUM_IN*8-1:0]    in_port
);

    localparam int unsigned AW          = $clog2(DEPTH_BYTES);
    localparam int unsigned DEPTH_WORDS = DEPTH_BYTES / 4;
    localparam logic [31:0] RAM_TOP     = 32'(DEPTH_BYTES);
    localparam logic [31:0] IO_SPAN     = 32'(NUM_OUT + NUM_IN);

    state_e                  state_q, state_d;
    rsp_src_e                src_q, src_d;
    logic [1:0]              type_q, type_d;
    logic [1:0]              off_q, off_d;
    logic                    sign_q, sign_d;
    logic                    err_q, err_d;
    logic [7:0]              io_byte_q, io_byte_d;
    logic [7:0]              err_count_q, err_count_d;
    logic [NUM_OUT-1:0][7:0] out_q, out_d;
    logic [NUM_IN-1:0][7:0]  sync1_q, sync1_d;
    logic [NUM_IN-1:0][7:0]  sync2_q, sync2_d;

    logic                    accept;
    logic [31:0]             io_off;
    logic                    in_ram, io_hit, is_out, is_in, fault;
    logic                    ram_re;
    logic [3:0]              ram_we;
    logic [31:0]             ram_wdata, ram_rdata, raw;
    logic [AW-3:0]           ram_addr;

    // Address decode and fault classification of the presented request.
    always_comb begin
        io_off = addr - IO_BASE;
        in_ram = addr < RAM_TOP;
        io_hit = (addr >= IO_BASE) && (io_off < IO_SPAN);
        is_out = io_hit && (io_off < 32'(NUM_OUT));
        is_in  = io_hit && !is_out;
        fault  = (acc_type == ACC_RSVD)
              || ((acc_type == ACC_HALF) && addr[0])
              || ((acc_type == ACC_WORD) && (addr[1:0] != 2'b00))
              || (!in_ram && !io_hit)
              || (io_hit && (acc_type != ACC_BYTE))
              || (rw && is_in);
        ram_addr = addr[AW-1:2];
        case (acc_type)
            ACC_WORD: ram_wdata = wdata;
            ACC_HALF: ram_wdata = {2{wdata[15:0]}};
            default:  ram_wdata = {4{wdata[7:0]}};
        endcase
    end

    // FSM next state and handshake outputs.
    always_comb begin
        req_ready = 1'b1;
        rsp_valid = 1'b0;
        state_d   = state_q;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
            end
            RESP: begin
                req_ready = 1'b1;
                rsp_valid = 1'b1;
            end
            default: ;
        endcase
        accept  = req_valid && req_ready;
        state_d = accept ? RESP : IDLE;
    end

    // Request execution: RAM/IO writes, response capture and fault counting.
    always_comb begin
        src_d       = SRC_NONE;
        type_d      = acc_type;
        off_d       = addr[1:0];
        sign_d      = sign_m;
        err_d       = 1'b0;
        io_byte_d   = '0;
        err_count_d = err_count_q;
        out_d       = out_q;
        ram_we      = '0;
        ram_re      = 1'b0;
        sync1_d     = in_port;
        sync2_d     = sync1_q;
        // Gating with rst keeps a write on the reset edge from reaching the
        // RAM banks, which have no reset of their own.
        if (accept && !rst) begin
            if (fault) begin
                err_d = 1'b1;
                if (err_count_q != 8'hFF) begin
                    err_count_d = err_count_q + 8'd1;
                end
            end else if (io_hit) begin
                if (rw) begin
                    for (int unsigned k = 0; k < NUM_OUT; k++) begin
                        if (io_off == 32'(k)) out_d[k] = wdata[7:0];
                    end
                end else begin
                    src_d = SRC_IO;
                    for (int unsigned k = 0; k < NUM_OUT; k++) begin
                        if (io_off == 32'(k)) io_byte_d = out_q[k];
                    end
                    for (int unsigned j = 0; j < NUM_IN; j++) begin
                        if (io_off == 32'(NUM_OUT + j)) io_byte_d = sync2_q[j];
                    end
                end
            end else if (rw) begin
                ram_we = lane_mask(acc_type, addr[1:0]);
            end else begin
                ram_re = 1'b1;
                src_d  = SRC_RAM;
            end
        end
    end

    // Response data: lane select of the registered RAM word, then extension.
    always_comb begin
        raw = '0;
        case (src_q)
            SRC_RAM: raw = ram_rdata >> {off_q, 3'b000};
            SRC_IO:  raw = {24'h00_0000, io_byte_q};
            default: raw = '0;
        endcase
        rdata = sext(raw, type_q, sign_q);
    end

    // State, response and IO registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            src_q       <= SRC_NONE;
            type_q      <= ACC_WORD;
            off_q       <= '0;
            sign_q      <= 1'b0;
            err_q       <= 1'b0;
            io_byte_q   <= '0;
            err_count_q <= '0;
            out_q       <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            type_q      <= type_d;
            off_q       <= off_d;
            sign_q      <= sign_d;
            err_q       <= err_d;
            io_byte_q   <= io_byte_d;
            err_count_q <= err_count_d;
            out_q       <= out_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
        end
    end

    dmem_byte_lanes #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_lanes (
        .clk   (clk),
        .re    (ram_re),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign err       = err_q;
    assign err_count = err_count_q;
    assign out_port  = out_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: expected responses are queued when a
// request is driven and compared when rsp_valid is observed.
module tb_data_mem_ctrl;
    import data_mem_pkg::*;

    localparam int unsigned DEPTH_BYTES = 1024;
    localparam int unsigned NUM_OUT     = 2;
    localparam int unsigned NUM_IN      = 2;
    localparam logic [31:0] IO_BASE     = 32'hFFFF_0000;

    logic                 clk, rst, req_valid, req_ready, rw, sign_m;
    logic [31:0]          addr, wdata, rdata;
    logic [1:0]           acc_type;
    logic                 rsp_valid, err;
    logic [7:0]           err_count;
    logic [NUM_OUT*8-1:0] out_port;
    logic [NUM_IN*8-1:0]  in_port;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_errs = 0;

    data_mem_ctrl #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .NUM_OUT     (NUM_OUT),
        .NUM_IN      (NUM_IN),
        .IO_BASE     (IO_BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rw        (rw),
        .addr      (addr),
        .wdata     (wdata),
        .acc_type  (acc_type),
        .sign_m    (sign_m),
        .rsp_valid (rsp_valid),
        .rdata     (rdata),
        .err       (err),
        .err_count (err_count),
        .out_port  (out_port),
        .in_port   (in_port)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one request for a single cycle and queue its expected response.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] t, input logic s,
                         input logic [31:0] er, input logic ee, input string tag);
        exp_t e;
        req_valid = 1'b1;
        rw        = w;
        addr      = a;
        wdata     = d;
        acc_type  = t;
        sign_m    = s;
        e.rdata   = er;
        e.err     = ee;
        e.tag     = tag;
        exp_q.push_back(e);
        if (ee && exp_errs != 255) exp_errs++;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Response monitor, sampling 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq({e.tag, "_rdata"}, rdata, e.rdata);
                    check_eq({e.tag, "_err"}, 32'(err), 32'(e.err));
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq({e.tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        acc_type = ACC_WORD; sign_m = 1'b0; in_port = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_err_count", 32'(err_count), 32'd0);
        check_eq("rst_out_port", 32'(out_port), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Word write then reads of every width and extension.
        issue(1, 32'h40, 32'h8765_4321, ACC_WORD, 0, 32'h0, 0, "wr_w40");
        issue(1, 32'h44, 32'h0000_0000, ACC_WORD, 0, 32'h0, 0, "wr_w44");
        issue(0, 32'h40, 32'h0, ACC_WORD, 0, 32'h8765_4321, 0, "rd_w40");
        issue(0, 32'h42, 32'h0, ACC_HALF, 1, 32'hFFFF_8765, 0, "rd_h42_s");
        issue(0, 32'h43, 32'h0, ACC_BYTE, 0, 32'h0000_0087, 0, "rd_b43_u");
        issue(0, 32'h43, 32'h0, ACC_BYTE, 1, 32'hFFFF_FF87, 0, "rd_b43_s");
        issue(0, 32'h40, 32'h0, ACC_HALF, 0, 32'h0000_4321, 0, "rd_h40_u");
        issue(0, 32'h41, 32'h0, ACC_BYTE, 1, 32'h0000_0043, 0, "rd_b41_s");

        // Misaligned accesses fault without touching memory.
        issue(0, 32'h41, 32'h0, ACC_HALF, 0, 32'h0, 1, "err_h41");
        issue(1, 32'h46, 32'hDEAD_BEEF, ACC_WORD, 0, 32'h0, 1, "err_w46");
        check_eq("err_count_2", 32'(err_count), 32'd2);
        issue(0, 32'h44, 32'h0, ACC_WORD, 0, 32'h0, 0, "rd_w44_kept");
        issue(0, 32'h40, 32'h0, ACC_WORD, 0, 32'h8765_4321, 0, "rd_w40_kept");

        // Half write into the upper lanes of a zeroed word.
        issue(1, 32'h20, 32'h0, ACC_WORD, 0, 32'h0, 0, "wr_w20");
        issue(1, 32'h22, 32'h1234_BEEF, ACC_HALF, 0, 32'h0, 0, "wr_h22");
        issue(0, 32'h20, 32'h0, ACC_WORD, 0, 32'hBEEF_0000, 0, "rd_w20");

        // Output port write/readback and IO faults.
        issue(1, IO_BASE + 32'd1, 32'h0000_00A5, ACC_BYTE, 0, 32'h0, 0, "wr_out1");
        check_eq("out_port_a5", 32'(out_port), 32'h0000_A500);
        issue(0, IO_BASE + 32'd1, 32'h0, ACC_BYTE, 0, 32'h0000_00A5, 0, "rd_out1");
        issue(1, IO_BASE + 32'd2, 32'h55, ACC_BYTE, 0, 32'h0, 1, "err_wr_in");
        issue(0, IO_BASE, 32'h0, ACC_WORD, 0, 32'h0, 1, "err_io_word");
        issue(0, 32'(DEPTH_BYTES), 32'h0, ACC_BYTE, 0, 32'h0, 1, "err_range");
        issue(0, 32'h10, 32'h0, ACC_RSVD, 0, 32'h0, 1, "err_rsvd");
        check_eq("err_count_6", 32'(err_count), 32'(exp_errs));
        check_eq("out_port_kept", 32'(out_port), 32'h0000_A500);

        // Input ports through the two-flop synchroniser.
        in_port = 16'h7F80;
        repeat (2) @(negedge clk);
        issue(0, IO_BASE + 32'(NUM_OUT), 32'h0, ACC_BYTE, 1, 32'hFFFF_FF80, 0, "rd_in0_s");
        issue(0, IO_BASE + 32'(NUM_OUT) + 32'd1, 32'h0, ACC_BYTE, 1, 32'h0000_007F, 0, "rd_in1_s");
        issue(0, IO_BASE + 32'(NUM_OUT), 32'h0, ACC_BYTE, 0, 32'h0000_0080, 0, "rd_in0_u");

        // Back-to-back read after write.
        issue(1, 32'h10, 32'h0000_0011, ACC_BYTE, 0, 32'h0, 0, "wr_b10");
        issue(0, 32'h10, 32'h0, ACC_BYTE, 0, 32'h0000_0011, 0, "rd_b10");
        issue(1, 32'h3FC, 32'hCAFE_F00D, ACC_WORD, 0, 32'h0, 0, "wr_w3fc");
        issue(0, 32'h3FC, 32'h0, ACC_WORD, 0, 32'hCAFE_F00D, 0, "rd_w3fc");

        // Reset during RESP, with a write presented on the reset edge.
        issue(0, 32'h40, 32'h0, ACC_WORD, 0, 32'h8765_4321, 0, "pre_rst_rd");
        rst = 1'b1; req_valid = 1'b1; rw = 1'b1; addr = 32'h40;
        wdata = 32'h0000_00FF; acc_type = ACC_BYTE; sign_m = 1'b0;
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        exp_errs = 0;
        check_eq("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_mid_err_count", 32'(err_count), 32'd0);
        check_eq("rst_mid_out_port", 32'(out_port), 32'd0);
        issue(0, 32'h40, 32'h0, ACC_WORD, 0, 32'h8765_4321, 0, "rd_rst_wr_dropped");

        // Saturation of the fault counter.
        for (int unsigned i = 0; i < 260; i++) begin
            issue(0, 32'h0, 32'h0, ACC_RSVD, 0, 32'h0, 1, "err_sat");
        end
        check_eq("err_count_sat", 32'(err_count), 32'(exp_errs));
        check_eq("err_count_255", 32'(err_count), 32'd255);

        repeat (2) @(negedge clk);
        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Next-generation data memory for the ARM core's MEM stage. Replaces the single-cycle combinational-read data store.
- Parametrised byte-addressed RAM with word/half/byte access, sign extension and a valid/ready request handshake.
- One-cycle registered read response; misalignment/range error reporting.
- N memory-mapped 8-bit output ports and M synchronised 8-bit input ports.

Parameters:
- DEPTH_BYTES, 1024: RAM size in bytes; power of two, multiple of 4.
- NUM_OUT, 2: number of 8-bit output ports.
- NUM_IN, 2: number of 8-bit input ports.
- IO_BASE, 32'hFFFF_0000: first IO byte address; must lie outside the RAM range.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- rw  in  1  1 = write, 0 = read.
- addr  in  32  byte address.
- wdata  in  32  write data, LSB-aligned.
- type  in  2  00 word, 01 half, 10 byte, 11 reserved.
- sign_m  in  1  sign-extend half/byte reads.
- rsp_valid  out  1  response valid; one cycle after accept.
- rdata  out  32  read data.
- err  out  1  request faulted; qualified by rsp_valid.
- err_count  out  8  saturating fault counter.
- out_port  out  NUM_OUT*8  output port registers; port k is bits [8k+7:8k].
- in_port  in  NUM_IN*8  asynchronous input ports.

Behaviour:
- Reset (rst high at posedge): rsp_valid=0, rdata=0, err=0, err_count=0, out_port=0, synchroniser flops=0, FSM=IDLE. RAM contents are not cleared.
- Accept: a request is accepted on a posedge with req_valid & req_ready.
- FSM states:
  - IDLE: req_ready=1; accept moves to RESP.
  - RESP: rsp_valid=1, req_ready=1; accept stays in RESP, otherwise return to IDLE.
  - Result: back-to-back throughput is one request per cycle, latency is 1.
- Reads: RAM is read synchronously at accept. rdata is registered and presented in RESP.
  - Word: {b3,b2,b1,b0}, little-endian.
  - Half: {16'h0 or 16 copies of bit15, b1,b0}.
  - Byte: {24'h0 or 24 copies of bit7, b0}.
- Writes: bytes are written at the accepting posedge using a lane mask (word 1111, half 0011 or 1100, byte one-hot). rdata=0 in RESP for writes.
- Read after write: a read accepted the cycle after a write to the same bytes returns the new data.
- Errors: err=1 in RESP, no state change, rdata=0 when any of these hold:
  - type=11;
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - addr >= DEPTH_BYTES and outside the IO window;
  - any IO access that is not a byte access;
  - a write to an input port.
- err_count increments by 1 on each error and saturates at 255.
- IO window:
  - IO_BASE+k (k<NUM_OUT): write sets out_port[k] at the accept edge; read returns the current value.
  - IO_BASE+NUM_OUT+j (j<NUM_IN): read returns the 2-flop-synchronised in_port[j], sign-extended per sign_m.
  - The input synchronisers run every cycle, regardless of requests.
- Reset mid-operation: a pending response is dropped (rsp_valid=0 next cycle). A write accepted on the same edge that rst is high is discarded.
- rsp_valid is not back-pressured; the consumer always takes responses.

Decomposition:
- Package data_mem_pkg holds:
  - access-type localparams ACC_WORD/ACC_HALF/ACC_BYTE/ACC_RSVD;
  - FSM state encoding IDLE/RESP;
  - function lane_mask(type, addr[1:0]);
  - function sext(data, type, sign_m).
- Sub-module dmem_byte_lanes: four 8-bit RAM banks of DEPTH_BYTES/4 entries each, with per-lane write enable and synchronous read (write-first). It is instantiated once.

Test Plan:
- Word write 0x8765_4321 @0x40, then word read @0x40: rsp_valid one cycle later, rdata=0x8765_4321, err=0.
- Reads @0x42 and @0x43 of that data:
  - half @0x42, sign_m=1: rdata=0xFFFF_8765;
  - byte @0x43, sign_m=0: rdata=0x0000_0087.
- Misalignment: half read @0x41 and word write @0x46: each gives err=1, rdata=0, memory unchanged, err_count=2.
- Output port: byte write 0xA5 @IO_BASE+1 → out_port[15:8]=0xA5 after the accept edge.
- Input port: drive in_port[7:0]=0x80, wait ≥2 cycles, byte read @IO_BASE+NUM_OUT with sign_m=1 → rdata=0xFFFF_FF80.
- Back-to-back and reset:
  - write 0x11 @0x10 then immediately read @0x10 (consecutive cycles): rdata=0x11;
  - assert rst during RESP: rsp_valid=0 next cycle;
  - after 256 errors, err_count=255.
